// File: rtl/aes192_key_schedule.sv
// rtl/aes192_key_schedule.sv - sequential AES-192 key expansion with 52-word bank and round-key readout
module aes192_key_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [191:0] key_in,
    input  logic [3:0]   rk_sel,
    output logic         busy,
    output logic         done,
    output logic         ready,
    output logic [127:0] rk_out
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state_q, state_d;
    logic [31:0]   w_q [52];
    logic [31:0]   w_d [52];
    logic [191:0]  cur_q, cur_d;
    logic [31:0]   rcon_q, rcon_d;
    logic [2:0]    iter_q, iter_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic [31:0]   temp;
    logic [31:0]   n_w [6];
    logic [5:0]    wbase;
    logic [5:0]    widx;
    logic [5:0]    rbase;
    logic          accept;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived arithmetically: multiplicative inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] x;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        x = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return x;
    endfunction

    always_comb begin
        temp = {sbox(cur_q[23:16]), sbox(cur_q[15:8]), sbox(cur_q[7:0]), sbox(cur_q[31:24])} ^ rcon_q;
        n_w[0] = temp ^ cur_q[191:160];
        for (int j = 1; j < 6; j++) begin
            n_w[j] = n_w[j-1] ^ cur_q[191-32*j -: 32];
        end
    end

    assign accept = start && (state_q != EXPAND);
    assign wbase  = ({3'b000, iter_q} * 6'd6) + 6'd6;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cur_d   = cur_q;
        rcon_d  = rcon_q;
        iter_d  = iter_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        widx    = 6'd0;
        if (accept) begin
            for (int j = 0; j < 6; j++) begin
                w_d[j] = key_in[191-32*j -: 32];
            end
            cur_d   = key_in;
            rcon_d  = 32'h0100_0000;
            iter_d  = 3'd0;
            ready_d = 1'b0;
            state_d = EXPAND;
        end else if (state_q == EXPAND) begin
            // Last pass lands at w[48]; writes beyond w[51] fall off the end
            for (int j = 0; j < 6; j++) begin
                widx = wbase + 6'(j);
                if (widx < 6'd52) w_d[widx] = n_w[j];
            end
            cur_d  = {n_w[0], n_w[1], n_w[2], n_w[3], n_w[4], n_w[5]};
            rcon_d = rcon_q << 1;
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                state_d = READY;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int k = 0; k < 52; k++) w_q[k] <= 32'h0;
            cur_q   <= 192'h0;
            rcon_q  <= 32'h0;
            iter_q  <= 3'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cur_q   <= cur_d;
            rcon_q  <= rcon_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign rbase = {rk_sel, 2'b00};

    always_comb begin
        rk_out = 128'h0;
        if (ready_q && (rk_sel <= 4'd12)) begin
            rk_out = {w_q[rbase], w_q[rbase + 6'd1], w_q[rbase + 6'd2], w_q[rbase + 6'd3]};
        end
    end

    assign busy  = (state_q == EXPAND);
    assign done  = done_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_aes192_key_schedule.sv
// tb/tb_aes192_key_schedule.sv - directed scoreboard bench for aes192_key_schedule
module tb_aes192_key_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [191:0] key_in;
    logic [3:0]   rk_sel;
    logic         busy;
    logic         done;
    logic         ready;
    logic [127:0] rk_out;

    typedef struct {
        logic [3:0]   sel;
        logic [127:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   cyc;

    localparam logic [191:0] KEY_A2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_ZERO = 192'h0;

    aes192_key_schedule dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .key_in (key_in),
        .rk_sel (rk_sel),
        .busy   (busy),
        .done   (done),
        .ready  (ready),
        .rk_out (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_a2();
        exp_q.push_back('{4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
        exp_q.push_back('{4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5});
        exp_q.push_back('{4'd12, 128'he98ba06f448c773c8ecc720401002202});
        exp_q.push_back('{4'd13, 128'h0});
    endtask

    task automatic push_zero();
        exp_q.push_back('{4'd0,  128'h0});
        exp_q.push_back('{4'd1,  128'h00000000000000006263636362636363});
        exp_q.push_back('{4'd15, 128'h0});
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rk_sel = e.sel;
            #1;
            check($sformatf("%s_rk%0d", tag, e.sel), rk_out, e.val);
        end
    endtask

    // Waits for done with a cycle budget; cyc counts edges after the accept edge
    task automatic wait_done(input string tag);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'd8);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_sel = 4'd0;
        tick();
        tick();
        check("rst_busy",  128'(busy),  128'd0);
        check("rst_done",  128'(done),  128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_rk",    rk_out,      128'd0);
        reset = 1'b0;
        tick();
        check("idle_rk", rk_out, 128'd0);

        // Basic expansion with FIPS-197 A.2 key
        key_in = KEY_A2;
        start  = 1'b1;
        push_a2();
        tick();
        start  = 1'b0;
        key_in = '1;
        check("e0_busy", 128'(busy), 128'd1);
        wait_done("a2");
        check("a2_ready", 128'(ready), 128'd1);
        check("a2_busy",  128'(busy),  128'd0);
        drain("a2");
        tick();
        check("a2_done_fall", 128'(done), 128'd0);

        // Re-expansion from READY with start pulses at E3, E5 and held across E8
        key_in = KEY_A2;
        start  = 1'b1;
        push_a2();
        tick();
        start  = 1'b0;
        check("re_ready_drop", 128'(ready), 128'd0);
        cyc = 0;
        while (!done && cyc < 20) begin
            start = (cyc == 2 || cyc == 4 || cyc == 7);
            key_in = KEY_ZERO;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("re_latency", 128'(cyc), 128'd8);
        tick();
        check("e8_start_busy",  128'(busy),  128'd0);
        check("e8_start_ready", 128'(ready), 128'd1);
        drain("re");

        // Reset mid-expansion aborts asynchronously
        key_in = KEY_ZERO;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick(); tick(); tick(); tick();
        rk_sel = 4'd1;
        reset  = 1'b1;
        #1;
        check("arst_busy",  128'(busy),  128'd0);
        check("arst_ready", 128'(ready), 128'd0);
        check("arst_rk",    rk_out,      128'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_busy", 128'(busy), 128'd0);
        key_in = KEY_A2;
        start  = 1'b1;
        push_a2();
        tick();
        start  = 1'b0;
        wait_done("post_rst");
        drain("post_rst");

        // Zero key from READY
        key_in = KEY_ZERO;
        start  = 1'b1;
        push_zero();
        tick();
        start  = 1'b0;
        check("zero_ready_drop", 128'(ready), 128'd0);
        wait_done("zero");
        check("zero_ready", 128'(ready), 128'd1);
        drain("zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes192_key_schedule.md
# aes192_key_schedule

Sequential AES-192 key schedule. It accepts a 192-bit cipher key, iterates the combinational 192-bit expansion step once per clock to build all 52 schedule words, and holds them in a register bank. It then serves any of the 13 128-bit round keys by index to the downstream cipher round datapath. It sits between the key input and the round pipeline, driving the expansion step and consuming the 192-bit block the step produces.

## Interface
- No parameters (Nk=6, Nr=12 and 52 words are fixed).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request to expand key_in; sampled on rising edge.
- key_in  in  192  cipher key; word 0 is key_in[191:160], word 5 is key_in[31:0].
- rk_sel  in  4  round-key index 0..12.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule completes.
- ready  out  1  level; schedule valid and readable.
- rk_out  out  128  round key rk_sel: words 4·rk_sel..4·rk_sel+3, lowest word in [127:96].

## Operation
- Storage: 52 × 32-bit word registers w[0..51], a 192-bit working block cur, a 32-bit rcon register, a 3-bit iteration counter iter.
- Expansion step, combinational, applied to cur: temp = SubWord(RotWord(cur[31:0])) ^ rcon, where RotWord is an 8-bit left rotate and SubWord is the AES S-box per byte. Then n0 = temp^cur[191:160], and for j=1..5, nj = n(j-1)^cur word j.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY with start=1: w[0..5] <= key_in, cur <= key_in, rcon <= 32'h01000000, iter <= 0, ready <= 0, go to EXPAND.
- EXPAND, each edge: write n0..n5 to w[6(iter+1)..6(iter+1)+5]. Writes with index >51 are discarded, so iter=7 writes only w[48..51]. Then cur <= {n0..n5}, rcon <= rcon<<1 (sequence 01,02,04,08,10,20,40,80; no xtime reduction needed), iter <= iter+1.
- EXPAND at iter=7: after writing, go to READY, ready <= 1, done <= 1 for that one cycle.
- start while in EXPAND: ignored. No queuing and no restart.
- start in READY: re-expansion. ready drops on the accepting edge and old words are overwritten progressively.
- rk_out is combinational from w[] and rk_sel. It is forced to 0 when ready=0 or rk_sel>12.
- key_in is sampled only on the accepting edge. It may change afterwards.

## Timing
- Reset, asynchronous: state=IDLE; busy=0, done=0, ready=0; all w, cur, rcon, iter cleared to 0; rk_out=0.
- Reset asserted mid-EXPAND aborts immediately to the reset values. After release, start is needed again.
- Accept edge E0 (start=1 in IDLE/READY). busy=1 from E0 through E8. On E8 busy=0, ready=1, done=1. done falls on E9.
- Total latency: 8 cycles from accept to ready.
- busy = (state==EXPAND). done is registered. ready is registered.
- rk_out has zero-cycle latency from rk_sel once ready=1.
- If start=1 on the same edge that completes EXPAND (E8), start is ignored because the state is still EXPAND.

## Test plan
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, pulse start -> done exactly 8 cycles later. rk_sel=0 -> 8e73b0f7da0e6452c810f32b809079e5. rk_sel=1 -> 62f8ead2522c6b7bfe0c91f72402f5a5. rk_sel=12 -> e98ba06f448c773c8ecc720401002202.
- All-zero key -> rk_sel=1 gives 000000000000000062636363626363 63, i.e. 0000000000000000626363636263636 3 read as words 00000000, 00000000, 62636363, 62636363.
- Before any start, or with rk_sel=13..15 while ready -> rk_out=0. busy=0 and done=0 out of reset.
- start re-pulsed at cycles E0+3 and E0+5 during EXPAND -> ignored; done still at E0+8 and results unchanged. start on the E8 edge -> no new expansion.
- Assert reset at E0+4 -> busy, ready and rk_out go 0 asynchronously. After release, new start with the A.2 key -> correct keys after 8 cycles.
- In READY, start with the zero key -> ready drops on the accept edge, then rises 8 cycles later with the zero-key schedule (rk_sel=0 -> 0).
